float_division: RTL and testbench
=================================

FLOAT_DIVISION -- requirements
Module: float_division

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  XLEN  dividend, IEEE-754 single.
REQ-006 B  input  XLEN  divisor, IEEE-754 single.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 result  output  XLEN  quotient A/B.
REQ-010 div_by_zero  output  1  flag, valid with done; held until the next accepted start.

Function
REQ-011 States: IDLE, DIVIDE, NORM, DONE.
- IDLE->DIVIDE on start.
- IDLE->DONE on start when the operands are a special case.
- DIVIDE->NORM after 25 iterations.
- NORM->DONE.
- DONE->IDLE unconditionally.
REQ-012 On the accepting edge, A and B are captured into internal registers; later changes on A and B have no effect.
REQ-013 start while busy is ignored; it is not queued.
REQ-014 Sign = A[31] XOR B[31] in all cases, including zero and infinity results.
REQ-015 Exponent field 0 means the operand is zero; subnormals are flushed to zero.
REQ-016 Special-case priority, highest first; all special cases bypass DIVIDE/NORM (done 2 cycles after start):
- (a) any exponent field 255: result 0x7FC00000;
- (b) B zero: result {sign,8'hFF,23'h0}, div_by_zero=1;
- (c) A zero: result {sign,31'h0}.
REQ-017 Mantissas: Ma={1,A[22:0]}, Mb={1,B[22:0]}, 24 bits each.
REQ-018 DIVIDE performs restoring division, one quotient bit per cycle, MSB first, for 25 cycles, producing q=floor(Ma*2^24/Mb); q is 25 bits.
REQ-019 Exponent and mantissa selection in NORM:
- q[24]=1: exponent e=Ea-Eb+127, mantissa q[23:1];
- otherwise: e=Ea-Eb+126, mantissa q[22:0].
REQ-020 e is computed signed, at least 10 bits.
REQ-021 Rounding is truncation (round toward zero); no sticky or guard handling.
REQ-022 Range limits:
- e>=255: result {sign,8'hFF,23'h0} (overflow to infinity);
- e<=0: result {sign,31'h0} (underflow to zero).
REQ-023 Normal-path latency: done high exactly 27 cycles after the start-sampling edge (edge 0).
REQ-024 result and div_by_zero update on the edge that raises done and hold until the next accepted start's completion.
REQ-025 busy falls in the same cycle done is high+1 (i.e., busy low after the DONE state); a start can be accepted in the cycle immediately after done.

Reset
REQ-026 rst overrides all other inputs, including a coincident start.
REQ-027 rst forces:
- state IDLE;
- busy=0, done=0, div_by_zero=0;
- result=0;
- quotient, remainder and iteration counter cleared.
REQ-028 rst asserted mid-DIVIDE aborts the operation; no done pulse is produced for the aborted request.

Verification
REQ-029 A=0x40CCCCCD (6.4), B=0x40000000 (2.0) -> done at edge 27, result=0x404CCCCD, div_by_zero=0.
REQ-030 A=0x3F800000, B=0x40400000 (1/3) -> result=0x3EAAAAAA (truncated).
REQ-031 A=0xC0CCCCCD (-6.4), B=0xBF000000 (-0.5) -> result=0x414CCCCD (12.8).
REQ-032 A=0x3F800000, B=0x80000000 -> done 2 cycles after start, result=0xFF800000, div_by_zero=1.
REQ-033 A=0x00000000, B=0x40A00000 -> result=0x00000000; then A=0x7F000000, B=0x00800000 -> result=0x7F800000 (overflow).
REQ-034 Control checks:
- start pulsed at cycle 10 of a running divide -> ignored, exactly one done;
- rst at cycle 12 -> busy=0, result=0 next cycle, no done pulse.

Source files
------------

// File: rtl/float_division.sv
// Iterative IEEE-754 single-precision divider: restoring division of the
// mantissas, truncating rounding, subnormals flushed to zero.
module float_division #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]      state;
  logic            sign;
  logic [7:0]      exp_a;
  logic [7:0]      exp_b;
  logic [23:0]     mant_b;
  logic [24:0]     rem;
  logic [24:0]     quo;
  logic [4:0]      cnt;
  logic [XLEN-1:0] pend_result;
  logic            pend_dbz;

  logic            in_sign;
  logic [7:0]      in_ea;
  logic [7:0]      in_eb;
  logic            special;
  logic [XLEN-1:0] spec_result;
  logic            spec_dbz;

  logic            ge;
  logic [24:0]     sub;
  logic [24:0]     rem_next;

  logic signed [10:0] e;
  logic [22:0]        mant_q;
  logic [XLEN-1:0]    norm_result;

  assign busy = (state != IDLE);

  // Special-operand classification, highest priority first.
  always_comb begin
    in_sign     = A[31] ^ B[31];
    in_ea       = A[30:23];
    in_eb       = B[30:23];
    special     = 1'b0;
    spec_result = '0;
    spec_dbz    = 1'b0;
    if (in_ea == 8'hFF || in_eb == 8'hFF) begin
      special     = 1'b1;
      spec_result = 32'h7FC0_0000;
    end else if (in_eb == 8'h00) begin
      special     = 1'b1;
      spec_result = {in_sign, 8'hFF, 23'h0};
      spec_dbz    = 1'b1;
    end else if (in_ea == 8'h00) begin
      special     = 1'b1;
      spec_result = {in_sign, 31'h0};
    end
  end

  // One restoring step: remainder stays below 2*Mb, so 25 bits suffice.
  always_comb begin
    ge       = (rem >= {1'b0, mant_b});
    sub      = rem - {1'b0, mant_b};
    rem_next = ge ? (sub << 1) : (rem << 1);
  end

  always_comb begin
    if (quo[24]) begin
      e      = $signed({3'b000, exp_a}) - $signed({3'b000, exp_b}) + 11'sd127;
      mant_q = quo[23:1];
    end else begin
      e      = $signed({3'b000, exp_a}) - $signed({3'b000, exp_b}) + 11'sd126;
      mant_q = quo[22:0];
    end
    if (e >= 11'sd255) begin
      norm_result = {sign, 8'hFF, 23'h0};
    end else if (e <= 11'sd0) begin
      norm_result = {sign, 31'h0};
    end else begin
      norm_result = {sign, e[7:0], mant_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      sign        <= 1'b0;
      exp_a       <= '0;
      exp_b       <= '0;
      mant_b      <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      pend_result <= '0;
      pend_dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign        <= in_sign;
            exp_a       <= in_ea;
            exp_b       <= in_eb;
            mant_b      <= {1'b1, B[22:0]};
            rem         <= {2'b01, A[22:0]};
            quo         <= '0;
            cnt         <= '0;
            pend_result <= spec_result;
            pend_dbz    <= spec_dbz;
            state       <= special ? DONE : DIVIDE;
          end
        end
        DIVIDE: begin
          quo <= {quo[23:0], ge};
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) state <= NORM;
        end
        NORM: begin
          pend_result <= norm_result;
          pend_dbz    <= 1'b0;
          state       <= DONE;
        end
        default: begin
          result      <= pend_result;
          div_by_zero <= pend_dbz;
          done        <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_division.sv
// Scoreboard bench for float_division: the driver queues expected responses,
// the monitor checks every done pulse against them.
module tb_float_division;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          edge_no;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  float_division #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Quotient computed directly from real-number reasoning on mantissas.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz, output logic spc);
    logic       s;
    int         ea, eb, e;
    longint     ma, mb, q;
    logic [31:0] man;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    dbz = 1'b0;
    spc = 1'b1;
    if (ea == 255 || eb == 255) res = 32'h7FC0_0000;
    else if (eb == 0) begin
      res = {s, 8'hFF, 23'h0};
      dbz = 1'b1;
    end else if (ea == 0) res = {s, 31'h0};
    else begin
      spc = 1'b0;
      ma  = longint'(a[22:0]) + 64'd8388608;
      mb  = longint'(b[22:0]) + 64'd8388608;
      q   = (ma * 64'd16777216) / mb;
      if (q >= 64'd16777216) begin
        e   = ea - eb + 127;
        man = 32'(q / 2);
      end else begin
        e   = ea - eb + 126;
        man = 32'(q);
      end
      if (e >= 255) res = {s, 8'hFF, 23'h0};
      else if (e <= 0) res = {s, 31'h0};
      else res = {s, 8'(e), man[22:0]};
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, w);
    end
  endtask

  // use_c selects constant expectations instead of the model.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic use_c, input logic [31:0] cres, input logic cdbz);
    exp_t        x;
    logic [31:0] mres;
    logic        mdbz, spc;
    wait_idle();
    model(a, b, mres, mdbz, spc);
    x.res     = use_c ? cres : mres;
    x.dbz     = use_c ? cdbz : mdbz;
    x.edge_no = cyc + 1 + (spc ? 1 : 27);
    x.a       = a;
    x.b       = b;
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_operand();
    int          r;
    logic [7:0]  ex;
    logic [31:0] v;
    r = $urandom_range(0, 19);
    if (r == 0) ex = 8'h00;
    else if (r == 1) ex = 8'hFF;
    else if (r < 4) ex = 8'($urandom_range(1, 10));
    else if (r < 6) ex = 8'($urandom_range(245, 254));
    else ex = 8'($urandom_range(1, 254));
    v = $urandom;
    v[30:23] = ex;
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at edge %0d, required no pulse", cyc);
        end else begin
          x = sb.pop_front();
          check("result", result, x.res);
          check("div_by_zero", 32'(div_by_zero), 32'(x.dbz));
          check("done_edge", 32'(cyc), 32'(x.edge_no));
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'h3F80_0000;
    B     = 32'h4000_0000;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    issue(32'h40CC_CCCD, 32'h4000_0000, 1'b1, 1'b1, 32'h404C_CCCD, 1'b0);
    issue(32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b1, 32'h3EAA_AAAA, 1'b0);
    issue(32'hC0CC_CCCD, 32'hBF00_0000, 1'b1, 1'b1, 32'h414C_CCCD, 1'b0);
    issue(32'h3F80_0000, 32'h8000_0000, 1'b1, 1'b1, 32'hFF80_0000, 1'b1);
    issue(32'h0000_0000, 32'h40A0_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    issue(32'h7F00_0000, 32'h0080_0000, 1'b1, 1'b1, 32'h7F80_0000, 1'b0);
    issue(32'h7F80_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h7FC0_0000, 1'b0);
    issue(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'hFF80_0000, 1'b1);
    issue(32'h0080_0000, 32'h7F00_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    drain();

    // A start raised mid-divide must be dropped, not queued.
    issue(32'h40CC_CCCD, 32'h4000_0000, 1'b1, 1'b1, 32'h404C_CCCD, 1'b0);
    repeat (9) @(negedge clk);
    A     = 32'h3F80_0000;
    B     = 32'h8000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    for (int i = 0; i < 150; i++) begin
      issue(rnd_operand(), rnd_operand(), 1'b1, 1'b0, 32'h0, 1'b0);
    end
    drain();

    // Leave a nonzero result and flag set, then abort a divide with reset.
    issue(32'h3F80_0000, 32'h8000_0000, 1'b1, 1'b1, 32'hFF80_0000, 1'b1);
    drain();
    issue(32'h40CC_CCCD, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (40) @(negedge clk);

    issue(32'h40CC_CCCD, 32'h4000_0000, 1'b1, 1'b1, 32'h404C_CCCD, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
